pipelined_add_sub: RTL and testbench
====================================

Name: pipelined_add_sub

Overview:
Parametrised, pipelined integer adder/subtractor. It is the successor to the combinational datapath Adder and is used where a registered, back-pressurable arithmetic unit is needed, such as a multi-cycle ALU path or the address/offset path of a pipelined core. The carry chain is split into STAGES equal segments, and one segment is resolved per clock. Each result carries carry, signed-overflow and zero flags. Both ends use a valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width in bits; must satisfy WIDTH % STAGES == 0.
- STAGES, 4, number of pipeline segments and latency in cycles; must be ≥ 1. SEG = WIDTH/STAGES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands this cycle.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  A±B modulo 2^WIDTH.
- carry_out  out  1  carry out of MSB. For subtraction, 1 = no borrow.
- overflow  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All stage valid bits, stage data, out_valid, result, carry_out, overflow and zero clear to 0 immediately.
  - in_ready = 1 while out_valid = 0.
  - In-flight operations are discarded; nothing emerges after release.
- Operand preparation at entry:
  - B' = sub ? ~src_b : src_b.
  - Carry-in c0 = sub.
- Pipeline operation:
  - Stage k (0..STAGES−1) adds bits [k*SEG +: SEG] of A and B' plus the carry registered from stage k−1. Stage 0 uses c0.
  - Stage k registers its SEG-bit sum slice, its carry, all lower completed slices, and the not-yet-used upper operand bits.
  - Each stage has a valid bit.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+STAGES-1. That is, exactly STAGES accepting edges from in_valid&&in_ready to out_valid.
- Flags, computed in the final stage and registered with the result:
  - carry_out = carry from the MSB slice.
  - overflow = (A[MSB] == B'[MSB]) && (result[MSB] != A[MSB]).
  - zero = (result == 0).
- Global stall:
  - advance = !out_valid || out_ready.
  - All stage registers (including their valid bits) update only when advance=1.
  - in_ready = advance (combinational).
  - Bubbles are not collapsed; invalid stages move along like valid ones.
- Handshakes:
  - Acceptance occurs when in_valid && in_ready.
  - When advance=1 and in_valid=0, a bubble (valid=0) enters stage 0.
  - The output holds result, all flags and out_valid stable while out_valid && !out_ready.
  - Simultaneous pop and push in the same cycle is allowed; throughput is 1 op/cycle.
- No reordering, dropping or duplication. Results leave in acceptance order.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.
- Values with out_valid=0 are don't-care except after reset, where all outputs are 0.

Test Plan (WIDTH=32, STAGES=4):
1. rst_n=0 for 2 cycles → out_valid=0, result=0, flags=0, in_ready=1. After release, out_valid remains 0 with no input.
2. Add 0xFFFF_FFFF + 0x0000_0001 (full carry ripple across all segments) → exactly 4 edges later: result=0x0000_0000, carry_out=1, zero=1, overflow=0.
3. Add 0x7FFF_FFFF + 0x0000_0001 → result=0x8000_0000, overflow=1, carry_out=0. Then sub 5−7 → result=0xFFFF_FFFE, carry_out=0, overflow=0, zero=0.
4. Sub 0x8000_0000 − 0x0000_0001 → result=0x7FFF_FFFF, overflow=1, carry_out=1.
5. 50 back-to-back random pairs with random add/sub, out_ready driven by a random ~50% pattern → every result matches the reference model, in order, with no drops or duplicates. in_ready=0 exactly when out_valid && !out_ready. Output is stable during stalls.
6. Three ops in flight, rst_n pulsed low mid-cycle → out_valid drops to 0 asynchronously. None of the three ops appear after release. A new op issued afterwards returns the correct result after 4 cycles.

Source files
------------

// File: rtl/pipelined_add_sub.sv
// Pipelined add/sub: carry chain split into STAGES segments, one resolved per clock; latency STAGES.
// Backpressure: the whole pipe (bubbles included) freezes while the output is held (out_valid && !out_ready).
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    // op_a/op_b hold only the operand bits this stage and later ones still need
    logic [REM-1:0]    op_a;
    logic [REM-1:0]    op_b;
    logic              cin;
    logic [SEG:0]      seg_sum;
    logic [LO+SEG-1:0] sum_d;
    logic [LO+SEG-1:0] sum_q;
    logic              vld_d;
    logic              vld_q;
    logic              cy_d;
    logic              cy_q;

    if (k == 0) begin : g_entry
      assign op_a  = src_a;
      assign op_b  = sub ? ~src_b : src_b;
      assign cin   = sub;
      assign vld_d = in_valid;
      assign sum_d = seg_sum[SEG-1:0];
    end else begin : g_link
      assign op_a  = g_stg[k-1].g_up.a_up_q;
      assign op_b  = g_stg[k-1].g_up.b_up_q;
      assign cin   = g_stg[k-1].cy_q;
      assign vld_d = g_stg[k-1].vld_q;
      assign sum_d = {seg_sum[SEG-1:0], g_stg[k-1].sum_q};
    end

    assign seg_sum = {1'b0, op_a[SEG-1:0]} + {1'b0, op_b[SEG-1:0]} + {{SEG{1'b0}}, cin};
    assign cy_d    = seg_sum[SEG];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        sum_q <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : g_up
      logic [REM-SEG-1:0] a_up_q;
      logic [REM-SEG-1:0] b_up_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_up_q <= '0;
          b_up_q <= '0;
        end else if (advance) begin
          a_up_q <= op_a[REM-1:SEG];
          b_up_q <= op_b[REM-1:SEG];
        end
      end
    end else begin : g_out
      logic ovf_d;
      logic ovf_q;
      logic zero_d;
      logic zero_q;

      assign ovf_d  = (op_a[REM-1] == op_b[REM-1]) && (sum_d[WIDTH-1] != op_a[REM-1]);
      assign zero_d = (sum_d == '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance) begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end

      assign out_valid = vld_q;
      assign result    = sum_q;
      assign carry_out = cy_q;
      assign overflow  = ovf_q;
      assign zero      = zero_q;
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed and random checks for pipelined_add_sub (WIDTH=32, STAGES=4).
module tb_pipelined_add_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_a     (src_a),
    .src_b     (src_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {carry, overflow, zero, result}
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [32:0] t;
    logic [31:0] r;
    logic        c;
    logic        v;
    if (s) begin
      t = {1'b0, a} - {1'b0, b};
      c = !t[32];
      r = t[31:0];
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end else begin
      t = {1'b0, a} + {1'b0, b};
      c = t[32];
      r = t[31:0];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end
    return {c, v, (r == 32'h0), r};
  endfunction

  // Single op into an empty pipe with out_ready=1; checks exact 4-edge latency.
  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] er, input logic ec, input logic ev, input logic ez);
    src_a    = a;
    src_b    = b;
    sub      = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1'b1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_c"}, carry_out, ec);
    chk({tag, "_v"}, overflow, ev);
    chk({tag, "_z"}, zero, ez);
    @(negedge clk);
  endtask

  logic [34:0] exp_q[$];
  logic [34:0] e;
  logic [35:0] held;
  logic        prev_stall;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        rs;
  int          sent;
  int          rcvd;
  int          cyc;
  int          seen;

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    src_a     = '0;
    src_b     = '0;
    sub       = 1'b0;
    #1 rst_n  = 1'b0;

    // 1: reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_res", result, 32'h0);
    chk("rst_flags", {carry_out, overflow, zero}, 3'b000);
    chk("rst_rdy", in_ready, 1'b1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_vld", out_valid, 1'b0);

    // 2-4: directed corner cases
    run_one("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("addovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("sub57",  32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("subeq",  32'h0000_1234, 32'h0000_1234, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // 5: random back-to-back traffic with random output backpressure
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    prev_stall = 1'b0;
    held = '0;
    ra = '0;
    rb = '0;
    rs = 1'b0;
    while (rcvd < 50 && cyc < 3000) begin
      if (prev_stall)
        chk("hold", {out_valid, carry_out, overflow, zero, result}, held);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 50) begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        src_a    = ra;
        src_b    = rb;
        sub      = rs;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ra, rb, rs));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rand_res", {carry_out, overflow, zero, result}, e);
        end
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      held = {out_valid, carry_out, overflow, zero, result};
      @(negedge clk);
      cyc++;
    end
    chk("rand_count", rcvd, 50);
    chk("rand_drain", exp_q.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rand_idle", out_valid, 1'b0);

    // 6: async reset with three ops in flight and a stalled output
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_a    = 32'h100 + 32'(i);
      src_b    = 32'h1;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_vld", out_valid, 1'b1);
    chk("pre_rst_res", result, 32'h101);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", out_valid, 1'b0);
    chk("arst_res", result, 32'h0);
    chk("arst_rdy", in_ready, 1'b1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flushed", seen, 0);
    run_one("post_rst", 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_000D, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
